dm_ctrl: RTL and testbench

- Next-generation data memory for the pipelined CPU's MEM stage.
- Adds parametrised depth and response latency, byte/halfword/word loads and stores with sign/zero extension, and misalignment/range error reporting.
- Adds a valid/ready request interface and a hardware clear sequencer that zeroes the array after reset.
- Sits between the MEM-stage pipeline register and the writeback mux; the stall logic consumes busy/req_ready.

---
 rtl/dm_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_dm_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data memory with byte/half/word access, sign/zero
// extension, error reporting, programmable response latency and a
// post-reset clear sequencer that zeroes every word before accepting work.
module dm_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1,
  parameter int LOG_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;

  // Per-request attributes captured at acceptance, used to shape the response.
  logic [1:0]        meta_size_q, meta_size_d;
  logic              meta_signed_q, meta_signed_d;
  logic [1:0]        meta_lane_q, meta_lane_d;
  logic              meta_zero_q, meta_zero_d;
  logic              meta_err_q, meta_err_d;

  // Last delivered response, shown on the outputs while resp_valid is low.
  logic [31:0]       hold_rdata_q, hold_rdata_d;
  logic              hold_err_q, hold_err_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word_q;

  logic              accept;
  logic              req_err;
  logic              store_commit;
  logic [ADDR_W-1:0] req_idx;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  logic [31:0]       cur_rdata;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign req_ready    = (state_q == S_IDLE) || (state_q == S_RESP);
  assign busy         = (state_q == S_CLEAR);
  assign resp_valid   = (state_q == S_RESP);
  assign accept       = req_valid && req_ready;
  assign req_idx      = req_addr[ADDR_W+1:2];
  assign store_commit = accept && req_we && !req_err;

  // Classify the request: illegal size, misalignment or address beyond the array.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (|req_addr[31:ADDR_W+2]) req_err = 1'b1;
  end

  // Single write port: the clear sequencer owns it in CLEAR, stores otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_be    = 4'b0000;
    mem_wdata = req_wdata;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clear_ptr_q;
      mem_be    = 4'b1111;
      mem_wdata = 32'h0;
    end else if (store_commit) begin
      mem_we = 1'b1;
      case (req_size)
        2'b00: begin
          mem_be    = 4'b0001 << req_addr[1:0];
          mem_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          mem_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{req_wdata[15:0]}};
        end
        default: mem_be = 4'b1111;
      endcase
    end
  end

  // Byte-enabled array write and registered read sampled at the acceptance edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
    if (accept) rd_word_q <= mem[req_idx];
  end

  // Control FSM: clear sweep, latency countdown and request capture.
  always_comb begin
    state_d       = state_q;
    clear_ptr_d   = clear_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    meta_size_d   = meta_size_q;
    meta_signed_d = meta_signed_q;
    meta_lane_d   = meta_lane_q;
    meta_zero_d   = meta_zero_q;
    meta_err_d    = meta_err_q;
    case (state_q)
      S_CLEAR: begin
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd1) state_d = S_RESP;
        else wait_cnt_d = wait_cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    if (accept) begin
      meta_size_d   = req_size;
      meta_signed_d = req_signed;
      meta_lane_d   = req_addr[1:0];
      meta_zero_d   = req_we || req_err;
      meta_err_d    = req_err;
      if (LATENCY == 1) begin
        state_d = S_RESP;
      end else begin
        state_d    = S_WAIT;
        wait_cnt_d = 4'(LATENCY - 1);
      end
    end
  end

  // Lane extraction and extension of the sampled word for the response.
  always_comb begin
    sel_byte  = 8'(rd_word_q >> {meta_lane_q, 3'b000});
    sel_half  = meta_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    cur_rdata = 32'h0;
    if (!meta_zero_q) begin
      case (meta_size_q)
        2'b00:   cur_rdata = meta_signed_q ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
        2'b01:   cur_rdata = meta_signed_q ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
        default: cur_rdata = rd_word_q;
      endcase
    end
  end

  // Remember the response being delivered so the outputs hold it afterwards.
  always_comb begin
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    if (state_q == S_RESP) begin
      hold_rdata_d = cur_rdata;
      hold_err_d   = meta_err_q;
    end
  end

  assign resp_rdata = resp_valid ? cur_rdata  : hold_rdata_q;
  assign resp_err   = resp_valid ? meta_err_q : hold_err_q;

  // State registers; reset drops any in-flight request and restarts the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CLEAR;
      clear_ptr_q   <= '0;
      wait_cnt_q    <= 4'd0;
      meta_size_q   <= 2'b00;
      meta_signed_q <= 1'b0;
      meta_lane_q   <= 2'b00;
      meta_zero_q   <= 1'b1;
      meta_err_q    <= 1'b0;
      hold_rdata_q  <= 32'h0;
      hold_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_ptr_q   <= clear_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      meta_size_q   <= meta_size_d;
      meta_signed_q <= meta_signed_d;
      meta_lane_q   <= meta_lane_d;
      meta_zero_q   <= meta_zero_d;
      meta_err_q    <= meta_err_d;
      hold_rdata_q  <= hold_rdata_d;
      hold_err_q    <= hold_err_d;
    end
  end

`ifndef SYNTHESIS
  generate
    if (LOG_EN != 0) begin : g_log
      logic [31:0] merged_word;

      // Word as it will look after the store commits, for the trace line.
      always_comb begin
        merged_word = mem[mem_idx];
        for (int i = 0; i < 4; i++) begin
          if (mem_be[i]) merged_word[i*8 +: 8] = mem_wdata[i*8 +: 8];
        end
      end

      // Trace each committed store.
      always @(posedge clk) begin
        if (reset && store_commit)
          $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged_word);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: two instances (LATENCY 1 and 3, 16 words),
// table vectors, hand sequences and random traffic against a byte-array model.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid1, valid3;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        ready1, rv1, err1, busy1;
  logic        ready3, rv3, err3, busy3;
  logic [31:0] rdata1, rdata3;

  int checks = 0;
  int errors = 0;

  // Behavioural model: one 64-byte array per instance.
  logic [7:0]  model_mem [2][64];
  logic [31:0] last_rdata [2];
  bit          last_err [2];

  always #5 clk = ~clk;

  dm_ctrl #(.ADDR_W(4), .LATENCY(1), .LOG_EN(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1), .busy(busy1));

  dm_ctrl #(.ADDR_W(4), .LATENCY(3), .LOG_EN(1)) dut3 (
    .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(rv3), .resp_rdata(rdata3), .resp_err(err3), .busy(busy3));

  function automatic bit rv_of(input int sel);
    return (sel == 0) ? rv1 : rv3;
  endfunction
  function automatic bit ready_of(input int sel);
    return (sel == 0) ? ready1 : ready3;
  endfunction
  function automatic bit busy_of(input int sel);
    return (sel == 0) ? busy1 : busy3;
  endfunction
  function automatic bit err_of(input int sel);
    return (sel == 0) ? err1 : err3;
  endfunction
  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? rdata1 : rdata3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 64; b++) model_mem[s][b] = 8'h00;
      last_rdata[s] = 32'h0;
      last_err[s]   = 1'b0;
    end
  endtask

  // Apply the access rules to the byte array; stores update it immediately.
  function automatic void model_access(input int sel, input bit we, input logic [1:0] size,
                                       input bit sgn, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output bit err);
    int n;
    longint v;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= 64);
    rdata = 32'h0;
    if (err) return;
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) model_mem[sel][int'(addr) + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(model_mem[sel][int'(addr) + i]) << (8 * i));
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      rdata = 32'(v);
    end
  endfunction

  // One complete transaction on instance sel; checks latency, wait-state
  // behaviour, response values and the hold afterwards.
  task automatic run_txn(input int sel, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit exp_err, input string nm);
    int lat = (sel == 0) ? 1 : 3;
    int n = 0;
    while (!ready_of(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({nm, "_ready_timeout"}, 32'(ready_of(sel)), 32'h1);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_pc = 32'h100 + addr;
    if (sel == 0) valid1 = 1'b1; else valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk({nm, "_wait_valid"}, 32'(rv_of(sel)), 32'h0);
      chk({nm, "_wait_ready"}, 32'(ready_of(sel)), 32'h0);
      chk({nm, "_wait_rdata_hold"}, rdata_of(sel), last_rdata[sel]);
      chk({nm, "_wait_err_hold"}, 32'(err_of(sel)), 32'(last_err[sel]));
    end
    @(negedge clk);
    chk({nm, "_resp_valid"}, 32'(rv_of(sel)), 32'h1);
    chk({nm, "_rdata"}, rdata_of(sel), exp_rdata);
    chk({nm, "_err"}, 32'(err_of(sel)), 32'(exp_err));
    $display("dut%0d %s we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
             lat, nm, we, size, sgn, addr, wdata, rdata_of(sel), err_of(sel));
    last_rdata[sel] = exp_rdata;
    last_err[sel]   = exp_err;
    @(negedge clk);
    chk({nm, "_after_valid"}, 32'(rv_of(sel)), 32'h0);
    chk({nm, "_after_rdata_hold"}, rdata_of(sel), last_rdata[sel]);
    chk({nm, "_after_err_hold"}, 32'(err_of(sel)), 32'(last_err[sel]));
  endtask

  // Count busy cycles after reset release; no response may appear meanwhile.
  task automatic check_clear(input int sel, input string nm);
    int cnt = 0;
    int rv_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rv_of(sel)) rv_seen++;
      if (!busy_of(sel)) break;
      cnt++;
    end
    chk({nm, "_busy_cycles"}, 32'(cnt), 32'd16);
    chk({nm, "_no_resp"}, 32'(rv_seen), 32'd0);
    chk({nm, "_ready_after"}, 32'(ready_of(sel)), 32'h1);
  endtask

  task automatic model_txn(input int sel, input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input string nm);
    logic [31:0] r;
    bit e;
    model_access(sel, we, size, sgn, addr, wdata, r, e);
    run_txn(sel, we, size, sgn, addr, wdata, r, e, nm);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1;
    bit e0, e1;
    bit rwe, rsgn;
    logic [1:0] rsize;
    logic [31:0] raddr;

    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'hDEADBEAB, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h1122AB44, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        32'hFFFFFFAB, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,        32'h00001122, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        32'h000000AB, 1'b0};
    tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h08, 32'h0,        32'hFFFFAB44, 1'b0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h0E, 32'h12348001, 32'h00000000, 1'b0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        32'h80010000, 1'b0};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        32'h00000000, 1'b1};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'h00000000, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 1'b0, 32'h3F, 32'h0000007F, 32'h00000000, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 32'h3F, 32'h0,        32'h0000007F, 1'b0};

    reset = 1'b0;
    valid1 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'h1);
    chk("rst_ready", 32'(ready1), 32'h0);
    chk("rst_resp_valid", 32'(rv1), 32'h0);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_err", 32'(err1), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    check_clear(0, "clear1");
    chk("clear3_done", 32'(busy3), 32'h0);

    // Table vectors on the single-cycle instance.
    for (int i = 0; i < 17; i++) begin
      model_access(0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, r0, e0);
      run_txn(0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("vec%0d", i));
    end

    // Full readback: the rejected out-of-range store must not have aliased.
    for (int w = 0; w < 16; w++) model_txn(0, 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, "readback1");

    // Back-to-back: store accepted in IDLE, dependent load accepted in RESP.
    while (!ready1) @(negedge clk);
    model_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, r0, e0);
    model_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r1, e1);
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_pc = 32'h200;
    valid1 = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'h0; req_pc = 32'h204;
    @(negedge clk);
    chk("b2b_store_valid", 32'(rv1), 32'h1);
    chk("b2b_store_rdata", rdata1, r0);
    chk("b2b_ready_in_resp", 32'(ready1), 32'h1);
    @(posedge clk);
    #1 valid1 = 1'b0;
    @(negedge clk);
    chk("b2b_load_valid", 32'(rv1), 32'h1);
    chk("b2b_load_rdata", rdata1, r1);
    $display("dut1 b2b store/load addr=00000010 -> rdata=%h", rdata1);
    last_rdata[0] = r1;
    last_err[0]   = e1;
    @(negedge clk);
    chk("b2b_after_valid", 32'(rv1), 32'h0);

    // Random traffic, LATENCY=1.
    for (int k = 0; k < 200; k++) begin
      rwe   = 1'($urandom % 2);
      rsgn  = 1'($urandom % 2);
      rsize = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      raddr = 32'($urandom_range(0, 71));
      if ($urandom % 4 != 0 && rsize != 2'd3) raddr = raddr & ~((32'h1 << rsize) - 32'h1);
      model_txn(0, rwe, rsize, rsgn, raddr, $urandom, "rand1");
    end

    // LATENCY=3 instance: directed store/load then random traffic.
    model_txn(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5A5A5, "lat3_store");
    model_txn(1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lat3_load");
    for (int k = 0; k < 60; k++) begin
      rwe   = ($urandom % 3 != 0);
      rsgn  = 1'($urandom % 2);
      rsize = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      raddr = 32'($urandom_range(0, 71));
      if ($urandom % 4 != 0 && rsize != 2'd3) raddr = raddr & ~((32'h1 << rsize) - 32'h1);
      model_txn(1, rwe, rsize, rsgn, raddr, $urandom | 32'h01010101, "rand3");
    end

    // Reset in the middle of a LATENCY=3 wait: response dropped, clear restarts.
    while (!ready3) @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20;
    valid3 = 1'b1;
    @(posedge clk);
    #1 valid3 = 1'b0;
    @(negedge clk);
    chk("midwait_ready", 32'(ready3), 32'h0);
    #1 reset = 1'b0;
    #1;
    chk("midwait_busy", 32'(busy3), 32'h1);
    chk("midwait_resp_valid", 32'(rv3), 32'h0);
    chk("midwait_ready_rst", 32'(ready3), 32'h0);
    chk("midwait_rdata", rdata3, 32'h0);
    chk("midwait_err", 32'(err3), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_clear(1, "clear3");
    clear_model();
    for (int w = 0; w < 16; w++) model_txn(1, 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, "readback3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
